// File: rtl/spi_txn_arbiter.sv
// Round-robin SPI frame sequencer: shares one cs/mosi/miso bus among NREQ requesters.
// Optional read-response checking on miso_oe is enabled with `define SPI_TXN_RESP_CHECK_EN.
module spi_txn_arbiter #(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_wr,
    input  logic [3*NREQ-1:0]   req_ext_addr,
    input  logic [3*NREQ-1:0]   req_reg_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rdata,
    output logic                err,
    output logic                cs,
    output logic                mosi,
    input  logic                miso,
    input  logic                miso_oe
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ARB, FRAME, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [4:0]      bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     sr_q, sr_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            cs_q, cs_d;
    logic            mosi_q, mosi_d;
    logic            wr_q, wr_d;
    logic            oe_ok_q, oe_ok_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [15:0]     frame;

    function automatic logic [PW-1:0] wrap_idx(input int v);
        return PW'(v % NREQ);
    endfunction

    // First requesting index at or above the rr pointer, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[wrap_idx(int'(rr_q) + i)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(int'(rr_q) + i);
            end
        end
    end

    // Frame bit k sits at frame[k]; reads send zero data.
    always_comb begin
        frame = {req_wr[win_idx] ? req_wdata[8*int'(win_idx) +: 8] : 8'h00,
                 req_reg_addr[3*int'(win_idx) +: 3], 1'b0,
                 req_ext_addr[3*int'(win_idx) +: 3], req_wr[win_idx]};
    end

`ifndef SPI_TXN_RESP_CHECK_EN
    logic unused_miso_oe;
    assign unused_miso_oe = miso_oe ^ oe_ok_q;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        wr_d    = wr_q;
        oe_ok_d = oe_ok_q;
        unique case (state_q)
            IDLE: begin
                if (|req && gap_q == '0) state_d = ARB;
            end
            ARB: begin
                if (win_found) begin
                    gnt_d   = NREQ'(1) << win_idx;
                    rr_d    = wrap_idx(int'(win_idx) + 1);
                    wr_d    = req_wr[win_idx];
                    sr_d    = frame >> 1;
                    mosi_d  = frame[0];
                    cs_d    = 1'b1;
                    bit_d   = '0;
                    oe_ok_d = 1'b1;
                    state_d = FRAME;
                end else begin
                    state_d = IDLE;
                end
            end
            FRAME: begin
                mosi_d = sr_q[0];
                sr_d   = sr_q >> 1;
                bit_d  = bit_q + 5'd1;
                if (bit_q >= 5'd9 && !wr_q) begin
                    rx_d    = {miso, rx_q[7:1]};
                    oe_ok_d = oe_ok_q & miso_oe;
                end
                if (bit_q == 5'd16) begin
                    cs_d    = 1'b0;
                    mosi_d  = 1'b0;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    bit_d   = '0;
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = GAP;
                    if (!wr_q) begin
`ifdef SPI_TXN_RESP_CHECK_EN
                        if (!(oe_ok_q & miso_oe)) begin
                            rdata_d = 8'h00;
                            err_d   = 1'b1;
                        end else begin
                            rdata_d = {miso, rx_q[7:1]};
                        end
`else
                        rdata_d = {miso, rx_q[7:1]};
`endif
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - GW'(1);
                // The idle check is folded in here so ARB follows the gap directly.
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = |req ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sr_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            mosi_q  <= 1'b0;
            wr_q    <= 1'b0;
            oe_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            wr_q    <= wr_d;
            oe_ok_q <= oe_ok_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized self-checking bench for spi_txn_arbiter against a frame-level reference model.
module tb_spi_txn_arbiter;
    localparam int NREQ = 2;
    localparam int GAP  = 1;

    logic              sclk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, req_wr, gnt, done;
    logic [3*NREQ-1:0] req_ext_addr, req_reg_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [7:0]        rdata;
    logic              err, cs, mosi, miso, miso_oe;

    spi_txn_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
        .sclk(sclk), .rst(rst), .req(req), .req_wr(req_wr),
        .req_ext_addr(req_ext_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;
    int rr_m = 0;
    logic [7:0] rdata_m = 8'h00;

    // observe_frame results
    logic [16:0]     bits_o;
    int              hi_o, lo_o;
    logic [NREQ-1:0] g_o, d_o;
    logic            dd_o, er_o, to_o;
    logic [7:0]      rd_o;

    function automatic logic [16:0] frame_model(logic wr, logic [2:0] ext, logic [2:0] rg, logic [7:0] wd);
        logic [16:0] f;
        f = '0;
        f[0] = wr;
        for (int b = 0; b < 3; b++) begin
            f[1 + b] = ext[b];
            f[5 + b] = rg[b];
        end
        for (int b = 0; b < 8; b++) f[8 + b] = wr ? wd[b] : 1'b0;
        return f;
    endfunction

    function automatic int pick(int rr, logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++)
            if (r[(rr + i) % NREQ]) return (rr + i) % NREQ;
        return -1;
    endfunction

    task automatic set_req(int i, logic wr, logic [2:0] ext, logic [2:0] rg, logic [7:0] wd);
        req_wr[i]              = wr;
        req_ext_addr[3*i +: 3] = ext;
        req_reg_addr[3*i +: 3] = rg;
        req_wdata[8*i +: 8]    = wd;
    endtask

    // Waits for cs, plays slave for 17 cycles, returns at the done cycle (negedge).
    task automatic observe_frame(input logic [7:0] resp, input logic oe, input int act_k,
                                 input logic [NREQ-1:0] req_act, input logic scramble);
        int t;
        to_o = 1'b0; lo_o = 0; hi_o = 0; bits_o = '0; dd_o = 1'b0;
        t = 0;
        @(negedge sclk);
        while (!cs && t < 200) begin
            lo_o++; t++;
            @(negedge sclk);
        end
        if (!cs) begin
            to_o = 1'b1;
            return;
        end
        g_o = gnt;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) @(negedge sclk);
            bits_o[k] = mosi;
            if (cs) hi_o++;
            if (|done) dd_o = 1'b1;
            miso    = (k >= 9) ? resp[k - 9] : 1'b0;
            miso_oe = (k >= 9) ? oe : 1'b0;
            if (k == act_k) req = req_act;
            if (scramble && k == 3) begin
                req_wr       = NREQ'($urandom);
                req_ext_addr = (3*NREQ)'($urandom);
                req_reg_addr = (3*NREQ)'($urandom);
                req_wdata    = (8*NREQ)'($urandom);
            end
        end
        @(negedge sclk);
        if (cs) hi_o++;
        d_o = done; rd_o = rdata; er_o = err;
        miso = 1'b0; miso_oe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_wr = '0; req_ext_addr = '0; req_reg_addr = '0;
        req_wdata = '0; miso = 1'b0; miso_oe = 1'b0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        checks++; if (gnt !== '0)   begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        checks++; if (done !== '0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (cs !== 1'b0)  begin errors++; $display("FAIL reset_cs: got %b want 0", cs); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        rst = 1'b0; rr_m = 0; rdata_m = 8'h00;
    endtask

    task automatic test_write();
        logic [16:0] seq;
        seq = 17'b0_1010_0101_0100_1011;
        set_req(0, 1'b1, 3'd5, 3'd2, 8'hA5);
        req = 2'b01;
        observe_frame(8'h00, 1'b1, -1, '0, 1'b0);
        req = '0;
        checks++; if (to_o) begin errors++; $display("FAIL write_timeout: cs never rose"); return; end
        checks++; if (bits_o !== seq) begin errors++; $display("FAIL write_mosi: got %b want %b", bits_o, seq); end
        checks++; if (bits_o !== frame_model(1'b1, 3'd5, 3'd2, 8'hA5)) begin errors++; $display("FAIL write_model: got %b", bits_o); end
        checks++; if (hi_o !== 17) begin errors++; $display("FAIL write_cs_len: got %0d want 17", hi_o); end
        checks++; if (g_o !== 2'b01) begin errors++; $display("FAIL write_gnt: got %b want 01", g_o); end
        checks++; if (d_o !== 2'b01 || dd_o) begin errors++; $display("FAIL write_done: got %b early=%b want 01", d_o, dd_o); end
        checks++; if (gnt !== '0) begin errors++; $display("FAIL write_gnt_clr: got %b want 0", gnt); end
        checks++; if (rd_o !== rdata_m || er_o !== 1'b0) begin errors++; $display("FAIL write_rdata: got %h/%b want %h/0", rd_o, er_o, rdata_m); end
        rr_m = 1;
    endtask

    task automatic test_read();
        set_req(0, 1'b0, 3'd1, 3'd4, 8'hFF);
        req = 2'b01;
        observe_frame(8'h3C, 1'b1, -1, '0, 1'b0);
        req = '0;
        checks++; if (to_o) begin errors++; $display("FAIL read_timeout: cs never rose"); return; end
        checks++; if (bits_o !== frame_model(1'b0, 3'd1, 3'd4, 8'hFF)) begin errors++; $display("FAIL read_mosi: got %b", bits_o); end
        checks++; if (rd_o !== 8'h3C || er_o !== 1'b0) begin errors++; $display("FAIL read_rdata: got %h/%b want 3c/0", rd_o, er_o); end
        rdata_m = 8'h3C; rr_m = (0 + 1) % NREQ;
        repeat (4) @(negedge sclk);
        checks++; if (rdata !== rdata_m) begin errors++; $display("FAIL read_hold: got %h want %h", rdata, rdata_m); end
    endtask

    task automatic test_resp_check();
        logic [7:0] exp_rd;
        logic       exp_er;
`ifdef SPI_TXN_RESP_CHECK_EN
        exp_rd = 8'h00; exp_er = 1'b1;
`else
        exp_rd = 8'h5A; exp_er = 1'b0;
`endif
        set_req(1, 1'b0, 3'd7, 3'd3, 8'h00);
        req = 2'b10;
        observe_frame(8'h5A, 1'b0, -1, '0, 1'b0);
        req = '0;
        checks++; if (to_o) begin errors++; $display("FAIL resp_timeout: cs never rose"); return; end
        checks++; if (rd_o !== exp_rd || er_o !== exp_er || d_o !== 2'b10) begin
            errors++; $display("FAIL resp_read: got rdata=%h err=%b done=%b want %h %b 10", rd_o, er_o, d_o, exp_rd, exp_er); end
        rdata_m = exp_rd; rr_m = 0;
        set_req(0, 1'b1, 3'd7, 3'd1, 8'h81);
        req = 2'b01;
        observe_frame(8'hFF, 1'b0, -1, '0, 1'b0);
        req = '0;
        checks++; if (er_o !== 1'b0 || rd_o !== rdata_m) begin errors++; $display("FAIL resp_write: got err=%b rdata=%h want 0 %h", er_o, rd_o, rdata_m); end
        rr_m = 1;
    endtask

    task automatic test_round_robin();
        int exp_w;
        set_req(0, 1'b1, 3'd2, 3'd6, 8'h11);
        set_req(1, 1'b1, 3'd4, 3'd5, 8'hE7);
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp_w = pick(rr_m, req);
            observe_frame(8'h00, 1'b1, -1, '0, 1'b0);
            checks++; if (to_o) begin errors++; $display("FAIL rr_timeout: frame %0d", f); req = '0; return; end
            checks++; if (g_o !== NREQ'(1) << exp_w || d_o !== g_o) begin
                errors++; $display("FAIL rr_grant: frame %0d gnt=%b done=%b want idx %0d", f, g_o, d_o, exp_w); end
            checks++; if (bits_o !== frame_model(req_wr[exp_w], req_ext_addr[3*exp_w +: 3], req_reg_addr[3*exp_w +: 3], req_wdata[8*exp_w +: 8])) begin
                errors++; $display("FAIL rr_mosi: frame %0d got %b", f, bits_o); end
            if (f > 0) begin
                checks++; if (lo_o + 1 !== GAP + 1) begin errors++; $display("FAIL rr_gap: got %0d want %0d", lo_o + 1, GAP + 1); end
            end
            rr_m = (exp_w + 1) % NREQ;
        end
        req = '0;
    endtask

    task automatic test_drop();
        set_req(0, 1'b1, 3'd3, 3'd3, 8'h3C);
        set_req(1, 1'b1, 3'd6, 3'd1, 8'h96);
        req = 2'b10;
        observe_frame(8'h00, 1'b1, 4, 2'b01, 1'b0);
        checks++; if (to_o) begin errors++; $display("FAIL drop_timeout: first frame"); req = '0; return; end
        checks++; if (g_o !== 2'b10 || d_o !== 2'b10) begin errors++; $display("FAIL drop_done: gnt=%b done=%b want 10", g_o, d_o); end
        checks++; if (bits_o !== frame_model(1'b1, 3'd6, 3'd1, 8'h96)) begin errors++; $display("FAIL drop_mosi: got %b", bits_o); end
        observe_frame(8'h00, 1'b1, -1, '0, 1'b0);
        req = '0;
        checks++; if (to_o || g_o !== 2'b01 || d_o !== 2'b01) begin errors++; $display("FAIL drop_skip: gnt=%b done=%b to=%b want 01", g_o, d_o, to_o); end
        rr_m = 1;
    endtask

    task automatic test_reset_mid();
        int t;
        logic saw_done;
        set_req(0, 1'b1, 3'd1, 3'd7, 8'hC3);
        req = 2'b01;
        t = 0;
        @(negedge sclk);
        while (!cs && t < 200) begin t++; @(negedge sclk); end
        checks++; if (!cs) begin errors++; $display("FAIL rstmid_timeout: cs never rose"); req = '0; return; end
        repeat (7) @(negedge sclk);
        rst = 1'b1; req = '0;
        @(negedge sclk);
        checks++; if (cs !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL rstmid_abort: cs=%b gnt=%b want 0 0", cs, gnt); end
        saw_done = |done;
        repeat (3) begin @(negedge sclk); saw_done |= |done; end
        rst = 1'b0; rr_m = 0; rdata_m = 8'h00;
        repeat (2) begin @(negedge sclk); saw_done |= |done; end
        checks++; if (saw_done !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL rstmid_nodone: done_seen=%b rdata=%h want 0 00", saw_done, rdata); end
        set_req(0, 1'b1, 3'd5, 3'd2, 8'hA5);
        req = 2'b01;
        observe_frame(8'h00, 1'b1, -1, '0, 1'b0);
        req = '0;
        checks++; if (to_o || hi_o !== 17 || d_o !== 2'b01 || bits_o !== frame_model(1'b1, 3'd5, 3'd2, 8'hA5)) begin
            errors++; $display("FAIL rstmid_recover: to=%b cs_len=%0d done=%b mosi=%b", to_o, hi_o, d_o, bits_o); end
        rr_m = 1;
    endtask

    task automatic test_random();
        int i;
        logic wr;
        logic [2:0] ext, rg;
        logic [7:0] wd, resp;
        for (int n = 0; n < 12; n++) begin
            i = $urandom_range(NREQ - 1);
            wr = 1'($urandom); ext = 3'($urandom); rg = 3'($urandom);
            wd = 8'($urandom); resp = 8'($urandom);
            set_req(i, wr, ext, rg, wd);
            req = NREQ'(1) << i;
            observe_frame(resp, 1'b1, -1, '0, 1'b1);
            req = '0;
            if (!wr) rdata_m = resp;
            checks++; if (to_o) begin errors++; $display("FAIL rand_timeout: iter %0d", n); return; end
            checks++; if (bits_o !== frame_model(wr, ext, rg, wd) || hi_o !== 17) begin
                errors++; $display("FAIL rand_mosi: iter %0d got %b len %0d want %b", n, bits_o, hi_o, frame_model(wr, ext, rg, wd)); end
            checks++; if (g_o !== NREQ'(1) << i || d_o !== g_o || rd_o !== rdata_m || er_o !== 1'b0) begin
                errors++; $display("FAIL rand_resp: iter %0d gnt=%b done=%b rdata=%h err=%b want idx %0d rdata %h", n, g_o, d_o, rd_o, er_o, i, rdata_m); end
            rr_m = (i + 1) % NREQ;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_resp_check();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
